// File: rtl/key_schedule_ctrl.sv
// Sequencer for AES-128 round-key expansion: drives an external keyExpansion unit once per round
// and holds the resulting round keys in a small register file with a combinational read port.
module key_schedule_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] cipher_key,
    output logic         busy,
    output logic         keys_ready,
    output logic         err,
    output logic         exp_enable,
    output logic [3:0]   exp_round_num,
    output logic [127:0] exp_past_key,
    input  logic [127:0] exp_new_key,
    input  logic         exp_done,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [127:0]    key_q [NUM_ROUNDS+1];

    logic            key_we;
    logic [3:0]      key_waddr;
    logic [127:0]    key_wdata;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        timer_d   = timer_q;
        key_we    = 1'b0;
        key_waddr = 4'd0;
        key_wdata = '0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // The cipher key is captured on the same edge that accepts start.
                if (start) begin
                    state_d   = S_LOAD;
                    key_we    = 1'b1;
                    key_waddr = 4'd0;
                    key_wdata = cipher_key;
                end
            end
            S_LOAD: begin
                round_d = 4'd1;
                state_d = S_REQ;
            end
            S_REQ: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (exp_done) begin
                    key_we    = 1'b1;
                    key_waddr = round_q;
                    key_wdata = exp_new_key;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_REQ;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            timer_q <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            timer_q <= timer_d;
            if (key_we) begin
                key_q[key_waddr] <= key_wdata;
            end
        end
    end

    assign busy          = (state_q == S_LOAD) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign keys_ready    = (state_q == S_DONE);
    assign err           = (state_q == S_ERROR);
    assign exp_enable    = (state_q == S_REQ);
    assign exp_round_num = ((state_q == S_REQ) || (state_q == S_WAIT)) ? round_q : 4'd0;
    assign exp_past_key  = (round_q == 4'd0) ? '0 : key_q[round_q - 4'd1];
    assign rd_key        = (rd_round > LAST_ROUND) ? '0 : key_q[rd_round];

endmodule
